// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (one radix-2 step per cycle).
// Optional MDU_DIV0_FLAG_EN adds a div_zero output that pulses with done on a divide by zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             w_accept;
    logic             w_busy;
    logic             w_last;

    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_rs_raw;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_count;
`ifdef MDU_DIV0_FLAG_EN
    logic             r_div_zero;
`endif

    logic             w_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A start is honoured in IDLE and in FINISH so results can issue back-to-back.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_count == LAST) begin
                    w_last       = 1'b1;
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_signed = ~op[0];
        w_rs_neg = w_signed & rs_data[WIDTH-1];
        w_rt_neg = w_signed & rt_data[WIDTH-1];
        w_rs_mag = w_rs_neg ? -rs_data : rs_data;
        w_rt_mag = w_rt_neg ? -rt_data : rt_data;
    end

    // Multiply: shift-add with the multiplier consumed from r_acc_lo[0].
    // Divide: restoring division, quotient bits shifted into r_acc_lo.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
        if (r_is_div) begin
            w_step_hi = w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_div_ok};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod     = {w_step_hi, w_step_lo};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        w_quo      = r_neg_q ? -w_step_lo : w_step_lo;
        w_rem      = r_neg_r ? -w_step_hi : w_step_hi;
        if (r_div0) begin
            w_fin_hi = r_rs_raw;
            w_fin_lo = '1;
        end else if (r_is_div) begin
            w_fin_hi = w_rem;
            w_fin_lo = w_quo;
        end else begin
            w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_rs_raw <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_count  <= '0;
`ifdef MDU_DIV0_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            r_div_zero <= 1'b0;
`endif
            if (!w_busy) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
            if (w_accept) begin
                r_is_div <= op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_div0   <= op[1] & (rt_data == '0);
                r_rs_raw <= rs_data;
                r_opnd   <= op[1] ? w_rt_mag : w_rs_mag;
                r_acc_lo <= op[1] ? w_rs_mag : w_rt_mag;
                r_acc_hi <= '0;
                r_count  <= '0;
            end
            if (w_busy) begin
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                r_count  <= r_count + 1'b1;
                if (w_last) begin
                    r_hi   <= w_fin_hi;
                    r_lo   <= w_fin_lo;
                    r_done <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                    r_div_zero <= r_div0;
`endif
                end
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
`ifdef MDU_DIV0_FLAG_EN
    assign div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit: expected HI/LO and completion cycle
// are queued at issue time and checked by an independent monitor.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic         div_zero;
`endif

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*W:0] exp_q[$];
    int           exp_cyc_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    bit           skip_busy = 1'b1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: {div0, hi, lo} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa, sb;
        logic [63:0]  p;
        int           ia, ib;
        logic [W-1:0] q, r;
        case (o)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        return {1'b0, 32'd0, 32'h8000_0000};
                    ia = $signed(a);
                    ib = $signed(b);
                    q  = 32'(ia / ib);
                    r  = 32'(ia % ib);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    bit           exp_busy;
    logic [2*W:0] mon_e;
    int           mon_c;

    always @(negedge clk) begin
        if (!skip_busy) begin
            exp_busy = (exp_cyc_q.size() > 0) && (cyc >= exp_cyc_q[0] - W) && (cyc < exp_cyc_q[0]);
            check("busy", W'(busy), W'(exp_busy));
`ifdef MDU_DIV0_FLAG_EN
            if (done !== 1'b1) check("div_zero_idle", W'(div_zero), '0);
`endif
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("done_cycle", W'(cyc), W'(mon_c));
                check("hi", hi, mon_e[2*W-1:W]);
                check("lo", lo, mon_e[W-1:0]);
`ifdef MDU_DIV0_FLAG_EN
                check("div_zero", W'(div_zero), W'(mon_e[2*W]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        exp_q.push_back(model(o, a, b));
        exp_cyc_q.push_back(cyc + W + 1);
        tick();
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        op      = 2'd0;
        rs_data = '0;
        rt_data = '0;
        wdata   = '0;
        repeat (3) tick();
        reset     = 1'b0;
        skip_busy = 1'b0;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
`ifdef MDU_DIV0_FLAG_EN
        check("rst_div_zero", W'(div_zero), '0);
`endif

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd3, 32'd100, 32'd0);
        wait_drain();

        // Start and MTHI while busy are both ignored.
        issue(2'd1, 32'd2, 32'd3);
        repeat (4) tick();
        start   = 1'b1;
        op      = 2'd3;
        rs_data = 32'd55;
        rt_data = 32'd7;
        mthi    = 1'b1;
        wdata   = 32'h1234;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        wait_drain();
        mthi  = 1'b1;
        wdata = 32'h1234;
        tick();
        mthi = 1'b0;
        check("mthi_idle", hi, 32'h1234);
        check("mthi_lo_kept", lo, 32'd6);

        // MTLO together with an accepted start lands, then the result overwrites it.
        wait_idle();
        mtlo    = 1'b1;
        wdata   = 32'hA5A5;
        op      = 2'd1;
        rs_data = 32'd7;
        rt_data = 32'd9;
        start   = 1'b1;
        exp_q.push_back(model(2'd1, 32'd7, 32'd9));
        exp_cyc_q.push_back(cyc + W + 1);
        tick();
        start = 1'b0;
        mtlo  = 1'b0;
        check("mtlo_with_start", lo, 32'hA5A5);
        wait_drain();

        // Reset mid-operation aborts without a done pulse.
        issue(2'd0, 32'd12345, 32'd678);
        repeat (9) tick();
        reset     = 1'b1;
        skip_busy = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        skip_busy = 1'b0;
        check("abort_busy", W'(busy), '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        repeat (W + 5) tick();
        check("abort_hi_later", hi, '0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 20)) tick();
                start   = 1'b1;
                mthi    = 1'b1;
                mtlo    = 1'b1;
                op      = 2'($urandom_range(0, 3));
                rs_data = $urandom;
                rt_data = $urandom;
                wdata   = $urandom;
                tick();
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
        end
        wait_drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
